// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_t     : arbiter FSM states (IDLE, RD_WAIT, WR_WAIT)
//   arb_owner_t     : which requester owns the in-flight access
//   WORD_ALIGN_MASK : clears the byte offset of a word address
//   addr_keep_mask  : mask of the low 'aw' address bits forwarded to memory
// Optional feature macro used by the arbiter files: MEM_ARB_ROUND_ROBIN_EN
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Bit b is set when b < aw; saturates to all-ones for aw >= 32.
  function automatic logic [31:0] addr_keep_mask(input int aw);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) begin
      m[b] = (b < aw);
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant selection between the fetch (I) and load/store (D)
// requesters. Evaluated only meaningfully while the arbiter is IDLE; the
// parent gates the result with its state.
//
// Ports:
//   i_valid_i    in  fetch request pending
//   d_valid_i    in  data request pending
//   last_owner_i in  owner of the most recently granted access
//   grant_i_o    out I wins this cycle
//   grant_d_o    out D wins this cycle
//
// Build option MEM_ARB_ROUND_ROBIN_EN: on contention the requester that was
// NOT last_owner wins. Without it, D always beats I and last_owner_i is
// ignored.
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_valid_i,
  input  logic       d_valid_i,
  input  arb_owner_t last_owner_i,
  output logic       grant_i_o,
  output logic       grant_d_o
);

  always_comb begin
    grant_i_o = 1'b0;
    grant_d_o = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_valid_i && d_valid_i) begin
      // Contention: alternate away from whoever went last.
      if (last_owner_i == OWN_D) begin
        grant_i_o = 1'b1;
      end else begin
        grant_d_o = 1'b1;
      end
    end else begin
      grant_i_o = i_valid_i;
      grant_d_o = d_valid_i;
    end
`else
    grant_d_o = d_valid_i;
    grant_i_o = i_valid_i & ~d_valid_i;
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = (last_owner_i == OWN_D);
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single mem_* port between the instruction-fetch unit (I) and the
// load/store unit (D). At most one access is outstanding.
//
// Handshake: a requester raises *_req_valid and holds it and its fields
// stable until *_req_ready is high; ready is combinational and high only in
// the IDLE cycle in which that requester wins the grant (the accept cycle T),
// and the fields are sampled in that cycle. The response is a one-cycle
// *_rsp_valid pulse carrying *_rsp_data; there is no backpressure on it.
//
// Timing: T accept -> T+1 one-cycle mem_rstrb (read) or mem_wmask (store)
// -> completion in the first cycle >= T+2 with the relevant busy low
// (read data captured then) -> rsp_valid the following cycle, which is
// already an IDLE cycle and may accept a new request.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   i_req_valid/i_req_addr/i_req_ready, i_rsp_valid/i_rsp_data   : fetch side
//   d_req_valid/d_req_addr/d_req_wdata/d_req_wmask/d_req_ready,
//   d_rsp_valid/d_rsp_data                                       : data side
//   mem_rdata/mem_rbusy/mem_wbusy (in), mem_rstrb/mem_addr/mem_wdata/
//   mem_wmask (out)                                              : memory port
//
// Parameters: ADDR_WIDTH (forwarded address bits), RESET_ADDR (mem_addr
// value in reset).
// Build option MEM_ARB_ROUND_ROBIN_EN: adds a last_owner register and
// alternates the grant under contention instead of fixed D-over-I priority.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 24,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wmask,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy,
  output logic        mem_rstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  // Upper bits beyond ADDR_WIDTH and the byte offset are forced to zero.
  localparam logic [31:0] ADDR_MASK = addr_keep_mask(ADDR_WIDTH) & WORD_ALIGN_MASK;

  arb_state_t  state_q;
  arb_owner_t  owner_q;
  logic        fresh_q;      // high in T+1: busy is not yet meaningful
  logic        mem_rstrb_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        i_rsp_valid_q;
  logic [31:0] i_rsp_data_q;
  logic        d_rsp_valid_q;
  logic [31:0] d_rsp_data_q;

  arb_owner_t  last_owner;
  logic        grant_i;
  logic        grant_d;
  logic        accept_i;
  logic        accept_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t  last_owner_q;
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_D;
`endif

  mem_arb_pick u_pick (
    .i_valid_i    (i_req_valid),
    .d_valid_i    (d_req_valid),
    .last_owner_i (last_owner),
    .grant_i_o    (grant_i),
    .grant_d_o    (grant_d)
  );

  // Ready is suppressed while reset is asserted so nothing is accepted then.
  assign accept_d = rst && (state_q == IDLE) && grant_d;
  assign accept_i = rst && (state_q == IDLE) && grant_i;

  assign i_req_ready = accept_i;
  assign d_req_ready = accept_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_D;
      fresh_q       <= 1'b0;
      mem_rstrb_q   <= 1'b0;
      mem_addr_q    <= RESET_ADDR;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q  <= OWN_D;
`endif
    end else begin
      // Strobes, masks and response pulses last a single cycle.
      fresh_q       <= 1'b0;
      mem_rstrb_q   <= 1'b0;
      mem_wmask_q   <= '0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            owner_q    <= OWN_D;
            fresh_q    <= 1'b1;
            mem_addr_q <= d_req_addr & ADDR_MASK;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_D;
`endif
            if (d_req_wmask != 4'b0000) begin
              mem_wmask_q <= d_req_wmask;
              mem_wdata_q <= d_req_wdata;
              state_q     <= WR_WAIT;
            end else begin
              mem_rstrb_q <= 1'b1;
              state_q     <= RD_WAIT;
            end
          end else if (accept_i) begin
            owner_q     <= OWN_I;
            fresh_q     <= 1'b1;
            mem_addr_q  <= i_req_addr & ADDR_MASK;
            mem_rstrb_q <= 1'b1;
            state_q     <= RD_WAIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_I;
`endif
          end
        end

        RD_WAIT: begin
          if (!fresh_q && !mem_rbusy) begin
            if (owner_q == OWN_D) begin
              d_rsp_data_q  <= mem_rdata;
              d_rsp_valid_q <= 1'b1;
            end else begin
              i_rsp_data_q  <= mem_rdata;
              i_rsp_valid_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end

        WR_WAIT: begin
          if (!fresh_q && !mem_wbusy) begin
            d_rsp_data_q  <= '0;
            d_rsp_valid_q <= 1'b1;
            state_q       <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rstrb   = mem_rstrb_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;

endmodule
